// File: rtl/spi_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_mem_pkg
// Brief    : Shared constants, state encoding and helpers for spi_mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package spi_mem_pkg;

    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SHIFT = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam logic [1:0] c_SIZE_BYTE = 2'd0;
    localparam logic [1:0] c_SIZE_HALF = 2'd1;
    localparam logic [1:0] c_SIZE_WORD = 2'd2;

    localparam logic c_PORT_FETCH = 1'b0;
    localparam logic c_PORT_DATA  = 1'b1;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        logic [2:0] v;
        case (size)
            c_SIZE_BYTE: v = 3'd1;
            c_SIZE_HALF: v = 3'd2;
            default:     v = 3'd4;
        endcase
        return v;
    endfunction

    // Received bytes arrive first-byte-highest; reorder to little-endian.
    function automatic logic [31:0] align_rdata(input logic [31:0] rx, input logic [1:0] size);
        logic [31:0] v;
        case (size)
            c_SIZE_BYTE: v = {24'h0, rx[7:0]};
            c_SIZE_HALF: v = {16'h0, rx[7:0], rx[15:8]};
            default:     v = {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_mem_arbiter_if
// Brief    : CPU-side fetch and load/store request bundle for spi_mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_mem_arbiter_if #(
    parameter int ADDR_W = 24
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic [31:0]       f_rdata;
    logic              f_done;

    logic              d_req;
    logic              d_we;
    logic [1:0]        d_size;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [31:0]       d_rdata;
    logic              d_done;
    logic              d_err;

    modport master (
        output f_req, f_addr, d_req, d_we, d_size, d_addr, d_wdata,
        input  f_rdata, f_done, d_rdata, d_done, d_err
    );

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_size, d_addr, d_wdata,
        output f_rdata, f_done, d_rdata, d_done, d_err
    );
endinterface
`default_nettype wire

// File: rtl/spi_shifter.sv
`default_nettype none
// ============================================================================
// Module   : spi_shifter
// Brief    : Mode-0 SPI bit engine: MSB-first shift-out, sclk = clk/2, miso capture.
// Revision : 1.0 - initial release
// ============================================================================
module spi_shifter #(
    parameter int FRAME_W = 64,
    parameter int CNT_W   = $clog2(FRAME_W + 1)
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               i_start,
    input  wire logic [FRAME_W-1:0] i_frame,
    input  wire logic [CNT_W-1:0]   i_nbits,
    input  wire logic               i_miso,
    output logic                    o_sclk,
    output logic                    o_mosi,
    output logic                    o_last,
    output logic [31:0]             o_rx
);

    logic [FRAME_W-1:0] r_sreg;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_active;
    logic               r_sclk;
    logic               r_last;
    logic [31:0]        r_rx;

    // Load happens on the grant edge, so the first cycle (START) holds sclk low
    // with cmd[7] already on mosi.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sreg   <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_sclk   <= 1'b0;
            r_last   <= 1'b0;
            r_rx     <= '0;
        end else begin
            r_last <= 1'b0;
            if (i_start) begin
                r_sreg   <= i_frame;
                r_cnt    <= i_nbits;
                r_active <= 1'b1;
                r_sclk   <= 1'b0;
            end else if (r_active) begin
                if (r_last) begin
                    r_active <= 1'b0;
                end else if (!r_sclk) begin
                    r_sclk <= 1'b1;
                end else begin
                    r_sclk <= 1'b0;
                    r_rx   <= {r_rx[30:0], i_miso};
                    r_cnt  <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_last <= 1'b1;
                        r_sreg <= '0;
                    end else begin
                        r_sreg <= {r_sreg[FRAME_W-2:0], 1'b0};
                    end
                end
            end
        end
    end

    assign o_sclk = r_sclk;
    assign o_mosi = r_sreg[FRAME_W-1];
    assign o_last = r_last;
    assign o_rx   = r_rx;

endmodule
`default_nettype wire

// File: rtl/spi_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_mem_arbiter
// Brief    : Shares one SPI bus between instruction fetch and load/store, routing
//            each transaction to the ROM or RAM chip-select by address MSB.
// Revision : 1.0 - initial release
// ============================================================================
module spi_mem_arbiter
    import spi_mem_pkg::*;
#(
    parameter int ADDR_W = 24
) (
    input  wire logic        clk,
    input  wire logic        rst,
    spi_mem_arbiter_if.slave bus,
    output logic             spi_sclk,
    output logic             spi_mosi,
    input  wire logic        spi_miso,
    output logic             spi_cs_rom_n,
    output logic             spi_cs_ram_n,
    output logic             busy
);

    localparam int c_HDR_W   = 8 + ADDR_W;
    localparam int c_FRAME_W = c_HDR_W + 32;
    localparam int c_CNT_W   = $clog2(c_FRAME_W + 1);

    state_t      r_state;
    logic        r_port;
    logic [1:0]  r_size;
    logic        r_cs_rom_n;
    logic        r_cs_ram_n;
    logic        r_busy;
    logic        r_f_done;
    logic        r_d_done;
    logic        r_d_err;
    logic [31:0] r_f_rdata;
    logic [31:0] r_d_rdata;

    logic                 w_grant_data;
    logic                 w_grant;
    logic                 w_we;
    logic                 w_rom_wr;
    logic                 w_start;
    logic                 w_last;
    logic [1:0]           w_size;
    logic [ADDR_W-1:0]    w_addr;
    logic [7:0]           w_cmd;
    logic [31:0]          w_wbytes;
    logic [c_FRAME_W-1:0] w_frame;
    logic [c_CNT_W-1:0]   w_nbits;
    logic [31:0]          w_rx;

    // Data port has fixed priority over fetch.
    assign w_grant_data = bus.d_req;
    assign w_grant      = bus.d_req | bus.f_req;
    assign w_we         = w_grant_data & bus.d_we;
    assign w_size       = w_grant_data ? bus.d_size : c_SIZE_WORD;
    assign w_addr       = w_grant_data ? bus.d_addr : bus.f_addr;
    assign w_rom_wr     = w_we & ~w_addr[ADDR_W-1];
    assign w_cmd        = w_we ? SPI_CMD_WRITE : SPI_CMD_READ;
    assign w_wbytes     = w_we ? {bus.d_wdata[7:0], bus.d_wdata[15:8],
                                  bus.d_wdata[23:16], bus.d_wdata[31:24]} : 32'h0;
    assign w_frame      = {w_cmd, w_addr, w_wbytes};
    assign w_nbits      = c_CNT_W'(c_HDR_W) + c_CNT_W'({size_bytes(w_size), 3'b000});
    assign w_start      = (r_state == ST_IDLE) & w_grant & ~w_rom_wr;

    spi_shifter #(
        .FRAME_W (c_FRAME_W),
        .CNT_W   (c_CNT_W)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_frame (w_frame),
        .i_nbits (w_nbits),
        .i_miso  (spi_miso),
        .o_sclk  (spi_sclk),
        .o_mosi  (spi_mosi),
        .o_last  (w_last),
        .o_rx    (w_rx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_port     <= c_PORT_FETCH;
            r_size     <= c_SIZE_WORD;
            r_cs_rom_n <= 1'b1;
            r_cs_ram_n <= 1'b1;
            r_busy     <= 1'b0;
            r_f_done   <= 1'b0;
            r_d_done   <= 1'b0;
            r_d_err    <= 1'b0;
            r_f_rdata  <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_f_done <= 1'b0;
            r_d_done <= 1'b0;
            r_d_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_port <= w_grant_data ? c_PORT_DATA : c_PORT_FETCH;
                        r_size <= w_size;
                        r_busy <= 1'b1;
                        // ROM writes are refused without touching the bus.
                        if (w_rom_wr) begin
                            r_d_done <= 1'b1;
                            r_d_err  <= 1'b1;
                            r_state  <= ST_STOP;
                        end else begin
                            r_cs_rom_n <= w_addr[ADDR_W-1];
                            r_cs_ram_n <= ~w_addr[ADDR_W-1];
                            r_state    <= ST_START;
                        end
                    end
                end
                ST_START: begin
                    r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (w_last) begin
                        r_cs_rom_n <= 1'b1;
                        r_cs_ram_n <= 1'b1;
                        r_state    <= ST_STOP;
                        if (r_port == c_PORT_DATA) begin
                            r_d_done  <= 1'b1;
                            r_d_rdata <= align_rdata(w_rx, r_size);
                        end else begin
                            r_f_done  <= 1'b1;
                            r_f_rdata <= align_rdata(w_rx, c_SIZE_WORD);
                        end
                    end
                end
                ST_STOP: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign spi_cs_rom_n = r_cs_rom_n;
    assign spi_cs_ram_n = r_cs_ram_n;
    assign busy         = r_busy;
    assign bus.f_rdata  = r_f_rdata;
    assign bus.f_done   = r_f_done;
    assign bus.d_rdata  = r_d_rdata;
    assign bus.d_done   = r_d_done;
    assign bus.d_err    = r_d_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_mem_arbiter
// Brief    : Scoreboard bench for spi_mem_arbiter with behavioural ROM/RAM SPI slaves.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_mem_arbiter;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic spi_miso = 1'b0;
    logic spi_sclk, spi_mosi, spi_cs_rom_n, spi_cs_ram_n, busy;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    spi_mem_arbiter_if #(.ADDR_W(24)) bus ();

    spi_mem_arbiter #(.ADDR_W(24)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .spi_sclk     (spi_sclk),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .spi_cs_rom_n (spi_cs_rom_n),
        .spi_cs_ram_n (spi_cs_ram_n),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- SPI slave model (ROM + RAM) ----------------
    logic [7:0]  rom  [0:4095];
    logic [7:0]  ram  [0:4095];
    logic [7:0]  sent [0:7];
    logic [31:0] hdr = '0;
    logic [7:0]  fr_cmd = '0;
    logic [23:0] fr_addr = '0;
    logic [7:0]  cur;
    logic        prev_sclk = 1'b0;
    logic        in_frame = 1'b0;
    logic        sel_ram = 1'b0;
    int bitn = 0, nsent = 0, idx = 0, bpos = 0;
    int rom_low = 0, ram_low = 0;
    int both_low_cnt = 0, sclk_rises = 0, cs_low_total = 0;

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4096; i++) begin
                rom[i] = 8'h00;
                ram[i] = 8'h00;
            end
            rom[16] = 8'h13; rom[17] = 8'h05; rom[18] = 8'h50; rom[19] = 8'h00;
            ram[256] = 8'h34; ram[257] = 8'h12;
            in_frame  = 1'b0;
            prev_sclk = 1'b0;
            bitn      = 0;
            spi_miso  = 1'b0;
        end else begin
            if (!spi_cs_rom_n && !spi_cs_ram_n) both_low_cnt++;
            if (!spi_cs_rom_n || !spi_cs_ram_n) begin
                cs_low_total++;
                if (!in_frame) begin
                    in_frame = 1'b1;
                    bitn     = 0;
                    nsent    = 0;
                    rom_low  = 0;
                    ram_low  = 0;
                    fr_cmd   = 8'h00;
                    sel_ram  = !spi_cs_ram_n;
                end
                if (!spi_cs_rom_n) rom_low++;
                if (!spi_cs_ram_n) ram_low++;
                if (spi_sclk && !prev_sclk) begin
                    sclk_rises++;
                    hdr  = {hdr[30:0], spi_mosi};
                    bitn++;
                    if (bitn % 8 == 0) begin
                        if (nsent < 8) sent[nsent] = hdr[7:0];
                        nsent++;
                        if (bitn == 32) begin
                            fr_cmd  = hdr[31:24];
                            fr_addr = hdr[23:0];
                        end
                        if (bitn > 32 && fr_cmd == 8'h02 && sel_ram) begin
                            idx = int'(fr_addr[11:0]) + (bitn - 40) / 8;
                            ram[idx[11:0]] = hdr[7:0];
                        end
                    end
                end else if (!spi_sclk && prev_sclk) begin
                    // Present the next read bit during phase B, ahead of the sampling edge.
                    if (bitn >= 32 && fr_cmd == 8'h03) begin
                        idx  = int'(fr_addr[11:0]) + (bitn - 32) / 8;
                        cur  = sel_ram ? ram[idx[11:0]] : rom[idx[11:0]];
                        bpos = 7 - ((bitn - 32) % 8);
                        spi_miso = cur[bpos[2:0]];
                    end
                end
            end else begin
                in_frame = 1'b0;
                if (spi_sclk && !prev_sclk) sclk_rises++;
            end
            prev_sclk = spi_sclk;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        chk_rd;
        logic        err;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb_q[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int frame_lat(input logic [1:0] size);
        int b;
        b = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        return 2 * (32 + 8 * b) + 2;
    endfunction

    task automatic issue_fetch(input logic [23:0] addr, input logic [31:0] exp, input int extra);
        exp_t e;
        e.port = 1'b0; e.rdata = exp; e.chk_rd = 1'b1; e.err = 1'b0;
        e.lat  = frame_lat(2'd2) + extra; e.t0 = cyc;
        sb_q.push_back(e);
        bus.f_addr = addr;
        bus.f_req  = 1'b1;
    endtask

    task automatic issue_data(input logic we, input logic [1:0] size, input logic [23:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp);
        exp_t e;
        e.port = 1'b1; e.rdata = exp; e.chk_rd = !we; e.err = we && !addr[23];
        e.lat  = e.err ? 1 : frame_lat(size); e.t0 = cyc;
        sb_q.push_back(e);
        bus.d_we    = we;
        bus.d_size  = size;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
        bus.d_req   = 1'b1;
    endtask

    task automatic wait_any_done();
        exp_t        e;
        logic        act_port;
        logic [31:0] act_rd;
        bit          got;
        got = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (bus.f_done || bus.d_done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            chk("done_timeout", 64'd0, 64'd1);
            if (sb_q.size() > 0) e = sb_q.pop_front();
            bus.f_req = 1'b0;
            bus.d_req = 1'b0;
            return;
        end
        if (sb_q.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
            return;
        end
        e        = sb_q.pop_front();
        act_port = bus.d_done;
        act_rd   = act_port ? bus.d_rdata : bus.f_rdata;
        chk("done_port", 64'(act_port), 64'(e.port));
        chk("both_done", 64'(bus.f_done && bus.d_done), 64'd0);
        if (e.chk_rd) chk("rdata", 64'(act_rd), 64'(e.rdata));
        chk("d_err", 64'(bus.d_err), 64'(e.err));
        chk("latency", 64'(cyc - e.t0), 64'(e.lat));
        if (act_port) bus.d_req = 1'b0;
        else          bus.f_req = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int s0, c0, seen;

    initial begin
        bus.f_req = 1'b0; bus.f_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = 2'd0; bus.d_addr = '0; bus.d_wdata = '0;

        repeat (3) @(negedge clk);
        chk("rst_cs_rom", 64'(spi_cs_rom_n), 64'd1);
        chk("rst_cs_ram", 64'(spi_cs_ram_n), 64'd1);
        chk("rst_sclk_mosi", 64'({spi_sclk, spi_mosi}), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done_err", 64'({bus.f_done, bus.d_done, bus.d_err}), 64'd0);
        chk("rst_rdata", {bus.f_rdata, bus.d_rdata}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Fetch from ROM
        issue_fetch(24'h000010, 32'h00500513, 0);
        wait_any_done();
        chk("fetch_mosi", 64'({sent[0], sent[1], sent[2], sent[3]}), 64'h03000010);
        chk("fetch_rom_low", 64'(rom_low), 64'd129);
        chk("fetch_ram_low", 64'(ram_low), 64'd0);
        @(negedge clk);

        // RAM byte write
        issue_data(1'b1, 2'd0, 24'h800004, 32'hAABBCC5A, 32'h0);
        wait_any_done();
        chk("bwr_mosi", 64'({sent[0], sent[1], sent[2], sent[3], sent[4]}), 64'h028000045A);
        chk("bwr_ram_low", 64'(ram_low), 64'd81);
        chk("bwr_rom_low", 64'(rom_low), 64'd0);
        chk("bwr_mem", 64'({ram[5], ram[4]}), 64'h005A);
        @(negedge clk);

        // RAM half read
        issue_data(1'b0, 2'd1, 24'h800100, 32'h0, 32'h00001234);
        wait_any_done();
        @(negedge clk);

        // RAM word write then word read back
        issue_data(1'b1, 2'd2, 24'h800200, 32'hDEADBEEF, 32'h0);
        wait_any_done();
        chk("wwr_data_mosi", 64'({sent[4], sent[5], sent[6], sent[7]}), 64'hEFBEADDE);
        @(negedge clk);
        issue_data(1'b0, 2'd3, 24'h800200, 32'h0, 32'hDEADBEEF);
        wait_any_done();
        @(negedge clk);

        // Simultaneous requests: data first, fetch granted in the IDLE after STOP
        issue_data(1'b0, 2'd0, 24'h800004, 32'h0, 32'h0000005A);
        issue_fetch(24'h000010, 32'h00500513, 83);
        wait_any_done();
        wait_any_done();
        chk("cs_overlap", 64'(both_low_cnt), 64'd0);
        @(negedge clk);

        // Write to ROM is refused
        s0 = sclk_rises;
        c0 = cs_low_total;
        issue_data(1'b1, 2'd2, 24'h000020, 32'h12345678, 32'h0);
        wait_any_done();
        repeat (3) @(negedge clk);
        chk("romwr_sclk", 64'(sclk_rises - s0), 64'd0);
        chk("romwr_cs", 64'(cs_low_total - c0), 64'd0);

        // Reset in the middle of a word read
        bus.d_we = 1'b0; bus.d_size = 2'd2; bus.d_addr = 24'h800200; bus.d_req = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_busy_before", 64'(busy), 64'd1);
        chk("abort_cs_before", 64'(spi_cs_ram_n), 64'd0);
        rst = 1'b1;
        #1;
        chk("abort_cs", 64'({spi_cs_rom_n, spi_cs_ram_n}), 64'b11);
        chk("abort_sclk", 64'(spi_sclk), 64'd0);
        bus.d_req = 1'b0;
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.f_done || bus.d_done || busy) seen++;
        end
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.f_done || bus.d_done || busy) seen++;
        end
        chk("abort_quiet", 64'(seen), 64'd0);
        issue_fetch(24'h000010, 32'h00500513, 0);
        wait_any_done();
        chk("final_overlap", 64'(both_low_cnt), 64'd0);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
